// File: rtl/shift_register_pkg.sv
// ============================================================================
// Module  : shift_register_pkg
// Brief   : Shared types and helpers for the shift-register block family.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_register_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } sipo_state_t;

    // Width of a counter that indexes 0..n-1; kept at least 1 bit for tiny n.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_register_sipo_framed.sv
// ============================================================================
// Module  : shift_register_sipo_framed
// Brief   : MSB-first framed SIPO deserializer with a two-deep output path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_register_sipo_framed
    import shift_register_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SI,
    input  logic         si_valid,
    output logic         si_ready,
    input  logic         sync,
    output logic [N-1:0] PO,
    output logic         po_valid,
    input  logic         po_ready,
    output logic         ovf,
    input  logic         ovf_clr
);

    localparam int               c_cnt_w   = cnt_width(N);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(N - 1);

    sipo_state_t        r_state;
    sipo_state_t        w_state_nxt;
    logic [N-1:0]       r_sh;
    logic [c_cnt_w-1:0] r_cnt;

    logic         w_accept;
    logic         w_consume;
    logic         w_complete;
    logic         w_out_free;
    logic [N-1:0] w_word;

    assign w_accept   = si_valid && si_ready;
    assign w_consume  = po_valid && po_ready;
    assign w_word     = {r_sh[N-2:0], SI};
    assign w_complete = w_accept && !sync && (r_cnt == c_cnt_max);
    // Output stage can take a new word if empty or being drained this edge.
    assign w_out_free = !po_valid || po_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_complete && !w_out_free) w_state_nxt = STALL;
            STALL:   if (w_consume)                 w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Output decode: depends only on registered state, never on po_ready.
    always_comb begin
        si_ready = (r_state == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh     <= '0;
            r_cnt    <= '0;
            PO       <= '0;
            po_valid <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (si_valid && !si_ready) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            if (r_state == STALL) begin
                // sh holds a complete word; it moves out only when PO drains.
                if (w_consume) begin
                    PO <= r_sh;
                end
            end else begin
                if (w_accept && sync) begin
                    r_sh  <= {{(N-1){1'b0}}, SI};
                    r_cnt <= c_cnt_w'(1);
                end else if (w_accept) begin
                    r_sh <= w_word;
                    if (r_cnt == c_cnt_max) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end else if (sync) begin
                    r_cnt <= '0;
                end

                if (w_complete && w_out_free) begin
                    PO       <= w_word;
                    po_valid <= 1'b1;
                end else if (w_consume) begin
                    po_valid <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_register_sipo_framed.sv
// ============================================================================
// Module  : tb_shift_register_sipo_framed
// Brief   : Directed self-checking bench for the framed SIPO deserializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_register_sipo_framed;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         SI;
    logic         si_valid;
    logic         si_ready;
    logic         sync;
    logic [N-1:0] PO;
    logic         po_valid;
    logic         po_ready;
    logic         ovf;
    logic         ovf_clr;

    int n_tests = 0;
    int n_fail  = 0;

    shift_register_sipo_framed #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .SI       (SI),
        .si_valid (si_valid),
        .si_ready (si_ready),
        .sync     (sync),
        .PO       (PO),
        .po_valid (po_valid),
        .po_ready (po_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b, input logic sy);
        SI       = b;
        si_valid = 1'b1;
        sync     = sy;
        step();
        si_valid = 1'b0;
        sync     = 1'b0;
        SI       = 1'b0;
    endtask

    task automatic idle();
        si_valid = 1'b0;
        sync     = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; SI = 1'b0; si_valid = 1'b0; sync = 1'b0;
        po_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        n_tests++;
        if (si_ready !== 1'b1 || po_valid !== 1'b0 || PO !== 8'h00 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: si_ready=%b po_valid=%b PO=%h ovf=%b, want 1 0 00 0",
                     si_ready, po_valid, PO, ovf);
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        w = 8'hA5;
        po_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            drive_bit(w[i], 1'b0);
            if (i != 0) begin
                n_tests++;
                if (po_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_early bit%0d: po_valid=%b want 0", 7 - i, po_valid);
                end
            end
        end
        n_tests++;
        if (po_valid !== 1'b1 || PO !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_word: po_valid=%b PO=%h, want 1 A5", po_valid, PO);
        end
        idle();
        n_tests++;
        if (po_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse_width: po_valid=%b want 0", po_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        stream = 16'h3CC3;
        po_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            SI = stream[15 - i]; si_valid = 1'b1; sync = 1'b0;
            n_tests++;
            if (si_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_si_ready cycle%0d: si_ready=%b want 1", i, si_ready);
            end
            step();
            n_tests++;
            if (po_valid !== (i == 7 || i == 15)) begin
                n_fail++;
                $display("FAIL b2b_valid cycle%0d: po_valid=%b want %b", i, po_valid, (i == 7 || i == 15));
            end
            if (i == 7 || i == 15) begin
                n_tests++;
                if (PO !== ((i == 7) ? 8'h3C : 8'hC3)) begin
                    n_fail++;
                    $display("FAIL b2b_data cycle%0d: PO=%h want %h", i, PO, (i == 7) ? 8'h3C : 8'hC3);
                end
            end
        end
        idle();
    endtask

    task automatic test_backpressure();
        logic [15:0] stream;
        stream = 16'h1122;
        po_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_bit(stream[15 - i], 1'b0);
            if (i == 7) begin
                n_tests++;
                if (po_valid !== 1'b1 || PO !== 8'h11 || si_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_first: po_valid=%b PO=%h si_ready=%b, want 1 11 1",
                             po_valid, PO, si_ready);
                end
            end
        end
        n_tests++;
        if (si_ready !== 1'b0 || PO !== 8'h11 || po_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_stall: si_ready=%b PO=%h po_valid=%b, want 0 11 1", si_ready, PO, po_valid);
        end
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if (ovf !== 1'b1 || si_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ovf: ovf=%b si_ready=%b, want 1 0", ovf, si_ready);
        end
        po_ready = 1'b1;
        step();
        n_tests++;
        if (PO !== 8'h22 || po_valid !== 1'b1 || si_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_drain: PO=%h po_valid=%b si_ready=%b, want 22 1 1", PO, po_valid, si_ready);
        end
        step();
        po_ready = 1'b0;
        n_tests++;
        if (po_valid !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_empty: po_valid=%b ovf=%b, want 0 1", po_valid, ovf);
        end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ovf_clr: ovf=%b want 0", ovf);
        end
        // The refused bit must not have advanced the counter.
        po_ready = 1'b1;
        for (int i = 7; i >= 0; i--) drive_bit(stream[i] ^ 1'b0 ? 1'b0 : 1'b0, 1'b0) ;
        n_tests++;
        if (po_valid !== 1'b1 || PO !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_clean_after_drop: po_valid=%b PO=%h, want 1 00", po_valid, PO);
        end
        idle();
    endtask

    task automatic test_resync();
        logic [7:0] w;
        po_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_bit(1'b1, 1'b0);
        w = 8'h81;
        drive_bit(w[7], 1'b1);
        for (int i = 6; i >= 0; i--) begin
            n_tests++;
            if (po_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL resync_early bit%0d: po_valid=%b want 0", 7 - i, po_valid);
            end
            drive_bit(w[i], 1'b0);
        end
        n_tests++;
        if (po_valid !== 1'b1 || PO !== 8'h81) begin
            n_fail++;
            $display("FAIL resync_word: po_valid=%b PO=%h, want 1 81", po_valid, PO);
        end
        idle();
        // Sync with no accepted bit also drops the partial word.
        for (int i = 0; i < 5; i++) drive_bit(1'b1, 1'b0);
        sync = 1'b1; si_valid = 1'b0;
        step();
        sync = 1'b0;
        w = 8'h6E;
        for (int i = 7; i >= 0; i--) drive_bit(w[i], 1'b0);
        n_tests++;
        if (po_valid !== 1'b1 || PO !== 8'h6E) begin
            n_fail++;
            $display("FAIL resync_idle_sync: po_valid=%b PO=%h, want 1 6E", po_valid, PO);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [15:0] stream;
        logic [7:0]  w;
        stream = 16'h0FF0;
        po_ready = 1'b0;
        for (int i = 15; i >= 0; i--) drive_bit(stream[i], 1'b0);
        drive_bit(1'b1, 1'b0);
        n_tests++;
        if (si_ready !== 1'b0 || po_valid !== 1'b1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_stall: si_ready=%b po_valid=%b ovf=%b, want 0 1 1", si_ready, po_valid, ovf);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (si_ready !== 1'b1 || po_valid !== 1'b0 || PO !== 8'h00 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_reset: si_ready=%b po_valid=%b PO=%h ovf=%b, want 1 0 00 0",
                     si_ready, po_valid, PO, ovf);
        end
        po_ready = 1'b1;
        w = 8'h96;
        for (int i = 7; i >= 0; i--) drive_bit(w[i], 1'b0);
        n_tests++;
        if (po_valid !== 1'b1 || PO !== 8'h96) begin
            n_fail++;
            $display("FAIL rstmid_clean: po_valid=%b PO=%h, want 1 96", po_valid, PO);
        end
        idle();
    endtask

    task automatic test_simultaneous();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h12;
        b = 8'h34;
        po_ready = 1'b0;
        for (int i = 7; i >= 0; i--) drive_bit(a[i], 1'b0);
        for (int i = 7; i >= 1; i--) drive_bit(b[i], 1'b0);
        n_tests++;
        if (PO !== 8'h12 || po_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_hold: PO=%h po_valid=%b, want 12 1", PO, po_valid);
        end
        po_ready = 1'b1;
        drive_bit(b[0], 1'b0);
        n_tests++;
        if (PO !== 8'h34 || po_valid !== 1'b1 || si_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_reload: PO=%h po_valid=%b si_ready=%b, want 34 1 1", PO, po_valid, si_ready);
        end
        idle();
        n_tests++;
        if (po_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_drain: po_valid=%b want 0", po_valid);
        end
        po_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_resync();
        test_reset_mid();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
